hci_ext_port_mux: RTL

- Multi-channel external TCDM front-end. Merges N_PORTS external initiator channels onto one HCI external initiator port of the interconnect, generalising the previous single fixed ext_tcdm port.
- Round-robin arbitration, bounded outstanding-transaction tracking, in-order response routing and a registered response stage honouring per-port r_ready backpressure.
- Sits between SoC-level external masters and the interconnect ext port inside the HCI system top.

---
 rtl/hci_ext_port_mux.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hci_ext_port_mux.sv
// Round-robin merge of N external initiator channels onto one HCI port,
// with in-order response routing through a single response register.
module hci_ext_port_mux #(
  parameter int unsigned N_PORTS         = 4,
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned BW              = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WRITE_HAS_RSP   = 0,
  localparam int unsigned BEW = DW / BW,
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic [N_PORTS-1:0]     ext_req_i,
  output logic [N_PORTS-1:0]     ext_gnt_o,
  input  logic [N_PORTS*AW-1:0]  ext_add_i,
  input  logic [N_PORTS-1:0]     ext_wen_i,
  input  logic [N_PORTS*DW-1:0]  ext_data_i,
  input  logic [N_PORTS*BEW-1:0] ext_be_i,
  output logic [N_PORTS*DW-1:0]  ext_r_data_o,
  output logic [N_PORTS-1:0]     ext_r_valid_o,
  input  logic [N_PORTS-1:0]     ext_r_ready_i,
  output logic                   tcdm_req_o,
  input  logic                   tcdm_gnt_i,
  output logic [AW-1:0]          tcdm_add_o,
  output logic                   tcdm_wen_o,
  output logic [DW-1:0]          tcdm_data_o,
  output logic [BEW-1:0]         tcdm_be_o,
  input  logic [DW-1:0]          tcdm_r_data_i,
  input  logic                   tcdm_r_valid_i,
  output logic                   tcdm_r_ready_o,
  output logic [CW-1:0]          outstanding_o,
  output logic                   err_o
);

  localparam int unsigned PW =
    (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned QW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(N_PORTS - 1);
  localparam logic [QW-1:0] LAST_Q = QW'(MAX_OUTSTANDING - 1);

  logic [PW-1:0] r_rr;
  logic [PW-1:0] r_ord [MAX_OUTSTANDING];
  logic [QW-1:0] r_wp;
  logic [QW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_rsp_v;
  logic [PW-1:0] r_rsp_p;
  logic [DW-1:0] r_rsp_d;
  logic          r_err;

  logic          w_any;
  logic          w_found;
  logic          w_wen;
  logic          w_full;
  logic          w_empty;
  logic          w_hs;
  logic          w_push;
  logic          w_racc;
  logic          w_pop;
  logic          w_rel;
  logic [PW-1:0] w_win;

  always_comb begin : arb
    int unsigned v_idx;
    logic [PW-1:0] v_p;
    v_idx   = 0;
    v_p     = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      v_idx = (32'(r_rr) + i) % N_PORTS;
      v_p   = PW'(v_idx);
      if (!w_found && ext_req_i[v_p]) begin
        w_win   = v_p;
        w_found = 1'b1;
      end
    end
  end

  assign w_any      = |ext_req_i;
  assign w_full     = (r_cnt == CW'(MAX_OUTSTANDING));
  assign w_empty    = (r_cnt == '0);
  // A full FIFO blocks requests even if a pop frees a slot this cycle
  assign tcdm_req_o = w_any && !w_full;
  assign w_hs       = tcdm_req_o && tcdm_gnt_i;
  assign w_wen      = ext_wen_i[w_win];
  assign w_push     = w_hs && (w_wen || (WRITE_HAS_RSP != 0));

  assign tcdm_r_ready_o = !r_rsp_v || ext_r_ready_i[r_rsp_p];
  assign w_racc = tcdm_r_valid_i && tcdm_r_ready_o;
  assign w_pop  = w_racc && !w_empty;
  assign w_rel  = r_rsp_v && ext_r_ready_i[r_rsp_p];

  always_comb begin : pay
    tcdm_add_o  = '0;
    tcdm_wen_o  = 1'b0;
    tcdm_data_o = '0;
    tcdm_be_o   = '0;
    ext_gnt_o   = '0;
    if (w_any) begin
      tcdm_add_o  = ext_add_i[32'(w_win)*AW +: AW];
      tcdm_wen_o  = w_wen;
      tcdm_data_o = ext_data_i[32'(w_win)*DW +: DW];
      tcdm_be_o   = ext_be_i[32'(w_win)*BEW +: BEW];
    end
    ext_gnt_o[w_win] = w_hs;
  end

  always_comb begin : rsp
    ext_r_valid_o = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      ext_r_valid_o[p] = r_rsp_v && (r_rsp_p == PW'(p));
    end
  end

  assign ext_r_data_o  = {N_PORTS{r_rsp_d}};
  assign outstanding_o = r_cnt;
  assign err_o         = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr    <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_rsp_v <= 1'b0;
      r_rsp_p <= '0;
      r_rsp_d <= '0;
      r_err   <= 1'b0;
    end else if (clear_i) begin
      r_rr    <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_rsp_v <= 1'b0;
      r_rsp_p <= '0;
      r_rsp_d <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr <= (w_win == LAST_P) ? '0 : w_win + 1'b1;
      end
      if (w_push) begin
        r_wp <= (r_wp == LAST_Q) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= (r_rp == LAST_Q) ? '0 : r_rp + 1'b1;
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_pop) begin
        r_rsp_v <= 1'b1;
        r_rsp_p <= r_ord[r_rp];
        r_rsp_d <= tcdm_r_data_i;
      end else if (w_rel) begin
        r_rsp_v <= 1'b0;
      end
      // A response with nothing in flight is dropped
      if (w_racc && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_ord[r_wp] <= w_win;
    end
  end

endmodule
